// File: rtl/bank_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : bank_fifo_drain
// Function : Read-side consumer of the dual-clock bank FIFO. Pulls one full
//            bank per burst and emits it on a valid/ready stream with last.
// Revision : 1.0 - initial release
// ============================================================================
module bank_fifo_drain #(
  parameter int          W               = 16,
  parameter int          N               = 8,
  // Reset value of the completed-bank counter; nonzero only for preload use.
  parameter logic [15:0] BANK_COUNT_INIT = 16'h0000
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         en,
  input  logic         f_ok,
  input  logic [W-1:0] f_data,
  output logic         f_trigger,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_last,
  output logic [15:0]  o_bankCount
);

  localparam int           c_BW       = 1 << (N - 1);
  localparam logic [N-2:0] c_LAST_IDX = (N - 1)'(c_BW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t       r_state;
  logic [N-2:0] r_wordCnt;

  logic w_accept;
  logic w_pop;
  logic w_lastPop;

  // The output register is single-entry: a pop is only allowed when it is
  // empty or being drained in this same cycle.
  assign w_accept  = o_valid && o_ready;
  assign w_pop     = (r_state == S_BURST) && f_ok && (!o_valid || o_ready);
  assign w_lastPop = w_pop && (r_wordCnt == c_LAST_IDX);
  assign f_trigger = w_pop;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state     <= S_IDLE;
      r_wordCnt   <= '0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_last      <= 1'b0;
      o_bankCount <= BANK_COUNT_INIT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en && f_ok) begin
            r_state   <= S_BURST;
            r_wordCnt <= '0;
          end
        end
        S_BURST: begin
          if (w_lastPop) begin
            r_state <= S_DONE;
          end
        end
        // Holding here until the last word drains gives the FIFO bank-toggle
        // bit time to settle so a stale f_ok cannot start a new burst.
        S_DONE: begin
          if (w_accept) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_pop) begin
        o_data    <= f_data;
        o_valid   <= 1'b1;
        o_last    <= (r_wordCnt == c_LAST_IDX);
        r_wordCnt <= r_wordCnt + 1'b1;
      end else if (w_accept) begin
        o_valid <= 1'b0;
      end

      if (w_accept && o_last) begin
        o_bankCount <= o_bankCount + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bank_fifo_drain.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for bank_fifo_drain: scenario table plus randomized handshakes,
// checked against a FIFO-order scoreboard of the popped words.
module tb_bank_fifo_drain;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int BW = 1 << (N - 1);

  typedef struct {
    int en;
    int en_drop;
    int fok_pct;
    int rdy_mode;
    int cycles;
    int exp_pops;
    int exp_banks;
    int exp_run;
    int exp_gap;
  } vec_t;

  logic         clk     = 1'b0;
  logic         rst_    = 1'b1;
  logic         en      = 1'b0;
  logic         f_ok    = 1'b0;
  logic         o_ready = 1'b0;
  logic [W-1:0] f_data;
  logic         f_trigger, o_valid, o_last;
  logic [W-1:0] o_data;
  logic [15:0]  o_bankCount;
  logic         p_trigger, p_valid, p_last;
  logic [W-1:0] p_data;
  logic [15:0]  p_bankCount;

  always #5 clk = ~clk;

  logic [W-1:0] mem [4096];
  logic [11:0]  rd_addr = '0;
  assign f_data = mem[rd_addr];

  bank_fifo_drain #(.W(W), .N(N)) dut (
    .clk(clk), .rst_(rst_), .en(en), .f_ok(f_ok), .f_data(f_data),
    .f_trigger(f_trigger), .o_valid(o_valid), .o_ready(o_ready),
    .o_data(o_data), .o_last(o_last), .o_bankCount(o_bankCount)
  );

  bank_fifo_drain #(.W(W), .N(N), .BANK_COUNT_INIT(16'hFFFF)) dut_pre (
    .clk(clk), .rst_(rst_), .en(en), .f_ok(f_ok), .f_data(f_data),
    .f_trigger(p_trigger), .o_valid(p_valid), .o_ready(o_ready),
    .o_data(p_data), .o_last(p_last), .o_bankCount(p_bankCount)
  );

  int           n_checks = 0;
  int           n_err    = 0;
  logic [11:0]  acc_idx  = '0;
  int           burst_pos = 0;
  logic [15:0]  exp_banks = '0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;
  bit           s_trig = 1'b0;
  vec_t         vecs [7];

  task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every accepted word must be the next FIFO word in pop order,
  // last marks every BW-th word of a burst, and a stalled word must hold.
  task automatic monitor();
    if (!f_ok) begin
      check_eq("no_pop_fok_low", 32'(f_trigger), 0);
      check_eq("pre_no_pop_fok_low", 32'(p_trigger), 0);
    end
    if (prev_stall) begin
      check_eq("stall_valid", 32'(o_valid), 1);
      check_eq("stall_data", 32'(o_data), 32'(prev_data));
      check_eq("stall_last", 32'(o_last), 32'(prev_last));
    end
    if (o_valid && !o_ready) check_eq("stall_no_pop", 32'(f_trigger), 0);
    check_eq("bankCount", 32'(o_bankCount), 32'(exp_banks));
    if (p_valid && o_ready) begin
      check_eq("pre_data", 32'(p_data), 32'(mem[acc_idx]));
      check_eq("pre_last", 32'(p_last), 32'(burst_pos == BW - 1));
    end
    if (o_valid && o_ready) begin
      check_eq("data", 32'(o_data), 32'(mem[acc_idx]));
      check_eq("last", 32'(o_last), 32'(burst_pos == BW - 1));
      acc_idx = acc_idx + 12'd1;
      if (burst_pos == BW - 1) begin
        burst_pos = 0;
        exp_banks = exp_banks + 16'd1;
      end else begin
        burst_pos++;
      end
    end
    prev_stall = o_valid && !o_ready;
    prev_data  = o_data;
    prev_last  = o_last;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next one.
  task automatic step();
    #1;
    monitor();
    s_trig = f_trigger;
    @(posedge clk);
    #1;
    if (s_trig) rd_addr = rd_addr + 12'd1;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int pops, run, max_run, gap, min_gap;
    bit seen;
    logic [15:0] bc0;
    pops = 0; run = 0; max_run = 0; gap = 0; min_gap = 1000000; seen = 1'b0;
    bc0 = o_bankCount;
    for (int c = 0; c < v.cycles; c++) begin
      en   = (v.en != 0) && (v.en_drop < 0 || pops < v.en_drop);
      f_ok = ($urandom_range(99) < v.fok_pct);
      case (v.rdy_mode)
        0:       o_ready = 1'b1;
        1:       o_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: o_ready = 1'($urandom_range(1));
      endcase
      step();
      if (s_trig) begin
        if (seen && run == 0 && gap < min_gap) min_gap = gap;
        seen = 1'b1;
        run++;
        gap = 0;
        if (run > max_run) max_run = run;
        pops++;
      end else begin
        run = 0;
        if (seen) gap++;
      end
    end
    check_eq($sformatf("v%0d_pops", id), pops, v.exp_pops);
    check_eq($sformatf("v%0d_banks", id), 32'(16'(o_bankCount - bc0)), v.exp_banks);
    check_eq($sformatf("v%0d_idle_valid", id), 32'(o_valid), 0);
    if (v.exp_run >= 0) check_eq($sformatf("v%0d_max_run", id), max_run, v.exp_run);
    if (v.exp_gap >= 0) begin
      n_checks++;
      if (min_gap < v.exp_gap || min_gap == 1000000) begin
        n_err++;
        $display("FAIL v%0d_gap: got %0d idle clks, expected at least %0d", id, min_gap, v.exp_gap);
      end
    end
  endtask

  initial begin
    int c;
    logic [11:0] a0;
    for (int i = 0; i < 4096; i++) mem[i] = W'($urandom);
    //          en drop fok rdy cyc  pops bk  run  gap
    vecs[0] = '{1,  1,  100, 0, 140,  128, 1, 128, -1};
    vecs[1] = '{1,  1,  100, 1, 400,  128, 1, -1,  -1};
    vecs[2] = '{1,  129,100, 0, 300,  256, 2, 128, 2};
    vecs[3] = '{0,  -1, 100, 0, 50,   0,   0, 0,   -1};
    vecs[4] = '{1,  40, 100, 0, 160,  128, 1, 128, -1};
    vecs[5] = '{1,  1,  100, 2, 900,  128, 1, -1,  -1};
    vecs[6] = '{1,  1,  70,  2, 1200, 128, 1, -1,  -1};

    #2 rst_ = 1'b0;
    #1;
    check_eq("rst_valid", 32'(o_valid), 0);
    check_eq("rst_data", 32'(o_data), 0);
    check_eq("rst_last", 32'(o_last), 0);
    check_eq("rst_bankCount", 32'(o_bankCount), 0);
    check_eq("rst_trigger", 32'(f_trigger), 0);
    check_eq("rst_pre_bankCount", 32'(p_bankCount), 32'h0000_FFFF);
    repeat (2) @(negedge clk);
    rst_ = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
      if (i == 0) check_eq("pre_bankCount_wrap", 32'(p_bankCount), 0);
    end

    // Asynchronous reset at word 60 of a burst, then a fresh full burst.
    en = 1'b1; f_ok = 1'b1; o_ready = 1'b1;
    a0 = rd_addr;
    c  = 0;
    while (12'(rd_addr - a0) < 12'd60 && c < 200) begin
      step();
      c++;
    end
    check_eq("reach_word60", 32'(12'(rd_addr - a0)), 60);
    rst_ = 1'b0;
    #1;
    check_eq("async_valid", 32'(o_valid), 0);
    check_eq("async_data", 32'(o_data), 0);
    check_eq("async_last", 32'(o_last), 0);
    check_eq("async_bankCount", 32'(o_bankCount), 0);
    check_eq("async_trigger", 32'(f_trigger), 0);
    acc_idx    = rd_addr;
    burst_pos  = 0;
    exp_banks  = '0;
    prev_stall = 1'b0;
    @(negedge clk);
    step();
    step();
    rst_ = 1'b1;
    run_vec(vecs[0], 7);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
